keyed_prio_intc: RTL and testbench
==================================

Name: keyed_prio_intc

Overview:
- Parametrised, registered successor of the 3-bus, 9-channel priority interrupt encoder in the ISCAS netlist set.
- Latches requests from NBUS prioritised request buses across NCH channels. Arbitrates one winner and presents it through a valid/ack handshake.
- Gated by a serially loaded unlock key. With a wrong key, no interrupt is ever presented. This keeps the block as a logic-locking benchmark for the DeCam SAT flows.

Parameters:
- NCH, 9, channels per bus (1..32)
- NBUS, 3, request buses; bus 0 highest priority (1..4)
- KEYW, 12, unlock key width in bits
- KEY, 12'hA5C, correct unlock key value

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NBUS*NCH  request pulses/levels; bit b*NCH+c = bus b, channel c
- chan_en  in  NCH  per-channel enable; a disabled channel neither latches nor wins
- key_in  in  1  serial key bit, MSB first
- key_shift  in  1  shift key_in into key register this cycle
- irq_valid  out  1  winner presented
- irq_bus  out  2  winning bus index
- irq_chan  out  5  winning channel index
- irq_ack  in  1  consumer accepts winner
- pend_any  out  1  OR of all enabled pending bits
- key_ok  out  1  key register == KEY

Behaviour:
- Reset, synchronous and active-high, has priority over every other input. Reset values:
  - pending array = 0
  - key register = 0
  - FSM state = LOCKED
  - irq_valid = 0, irq_bus = 0, irq_chan = 0
  - pend_any = 0
  - key_ok = (KEY == 0)
- Pending latch: on each clock, pend[b][c] <= pend[b][c] | (req[b][c] & chan_en[c]), minus the bit cleared by ack. Set and clear of the same bit in the same cycle: set wins, so a new request is not lost.
- Key register: on key_shift, keyreg <= {keyreg[KEYW-2:0], key_in}. key_ok is the registered compare, updated the cycle after the shift.
- Arbitration is combinational over the pending bits:
  - lowest bus index with any enabled pending bit wins;
  - within that bus, lowest channel index wins.
- FSM states: LOCKED, IDLE, GRANT.
  - LOCKED: irq_valid=0; pending bits still latch. Go to IDLE when key_ok=1.
  - IDLE: if key_ok=0, go to LOCKED. Otherwise, if any enabled pending bit exists, register the winner into irq_bus/irq_chan, set irq_valid=1 and go to GRANT. Latency: request at edge N is latched at N; irq_valid is high after edge N+1.
  - GRANT: irq_bus/irq_chan/irq_valid stay stable until ack, even if a higher-priority request arrives.
    - On irq_ack=1: clear the granted pending bit, drop irq_valid, go to IDLE.
    - Minimum one idle cycle between grants.
    - If key_ok drops (key reshifted) while in GRANT: abort, irq_valid=0, pending kept, go to LOCKED.
- chan_en deasserted for a pending channel: its bit is masked from arbitration but retained. It becomes eligible again when re-enabled.
- irq_ack outside GRANT is ignored.
- pend_any is registered and reflects enabled pending bits after the update.
- Width rule: irq_chan is zero-extended to 5 bits; irq_bus is zero-extended to 2 bits.

Decomposition:
- Package intc_pkg holds:
  - FSM state enum (LOCKED, IDLE, GRANT);
  - CHW=5 and BUSW=2 constants;
  - the function returning the flat req index from bus and channel.
- One sub-module: prio_find_first (parameter W), a combinational lowest-index-first finder with outputs found and idx. It is instantiated once per bus and once across buses.

Test Plan:
- Reset then no key shifted; req bus0 ch3 with chan_en all ones -> irq_valid stays 0 for 50 cycles, pend_any=1, FSM LOCKED.
- Shift 12'hA5C MSB first -> key_ok=1 one cycle after the last shift. The pending bus0 ch3 then gives irq_valid=1, irq_bus=0, irq_chan=3. Ack -> irq_valid=0 next cycle, pend_any=0.
- Unlocked; req bus2 ch0 and bus1 ch8 in the same cycle -> first grant bus1 ch8. After ack, one idle cycle, then grant bus2 ch0.
- Unlocked; grant presented for bus1 ch5; then req bus0 ch0 arrives -> grant holds bus1 ch5 until ack; next grant is bus0 ch0.
- Unlocked; chan_en[4]=0, req bus0 ch4 -> no latch, irq_valid=0. Request pending with chan_en=0, then chan_en[4]=1 -> grant bus0 ch4.
- During GRANT, shift one wrong bit -> key_ok=0, irq_valid=0 next cycle, pending retained. Assert rst mid-GRANT -> all outputs return to reset values the following cycle.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the keyed priority interrupt controller.
// Contents:
//   intc_state_e : controller state (LOCKED, IDLE, GRANT)
//   CHW, BUSW    : widths of the presented channel / bus indices
//   flat_idx()   : flat request-vector index for a (bus, channel) pair
package intc_pkg;

  localparam int CHW  = 5;
  localparam int BUSW = 2;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    IDLE   = 2'd1,
    GRANT  = 2'd2
  } intc_state_e;

  // Bus b, channel c lives at bit b*nch + c of the flat request vector.
  function automatic int unsigned flat_idx(input int unsigned bus,
                                           input int unsigned chan,
                                           input int unsigned nch);
    return bus * nch + chan;
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational lowest-index-first finder.
// Ports:
//   vec   : input bit vector, bit 0 has the highest priority
//   found : at least one bit of vec is set
//   idx   : index of the lowest set bit (0 when none is set)
module prio_find_first #(
  parameter  int W  = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan upwards; the first set bit freezes idx because found is already high afterwards.
  always_comb begin
    found = 1'b0;
    idx   = {IW{1'b0}};
    for (int i = 0; i < W; i++) begin
      idx   = (vec[i] && !found) ? IW'(i) : idx;
      found = found | vec[i];
    end
  end

endmodule

// File: rtl/keyed_prio_intc.sv
// Key-locked, registered priority interrupt controller.
// Requests from NBUS buses of NCH channels are latched into a pending array,
// one winner (lowest bus, then lowest channel) is presented through a
// valid/ack handshake, and nothing is ever presented unless the serially
// loaded key register matches KEY.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   req[NBUS*NCH]      : requests, bit b*NCH+c = bus b, channel c
//   chan_en[NCH]       : per-channel enable (masks latch and arbitration)
//   key_in, key_shift  : serial key load, MSB first
//   irq_valid/bus/chan : presented winner
//   irq_ack            : consumer accepts the presented winner
//   pend_any           : any enabled pending bit
//   key_ok             : key register equals KEY
module keyed_prio_intc
  import intc_pkg::*;
#(
  parameter int              NCH  = 9,
  parameter int              NBUS = 3,
  parameter int              KEYW = 12,
  parameter logic [KEYW-1:0] KEY  = 12'hA5C
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBUS*NCH-1:0]  req,
  input  logic [NCH-1:0]       chan_en,
  input  logic                 key_in,
  input  logic                 key_shift,
  output logic                 irq_valid,
  output logic [BUSW-1:0]      irq_bus,
  output logic [CHW-1:0]       irq_chan,
  input  logic                 irq_ack,
  output logic                 pend_any,
  output logic                 key_ok
);

  localparam int NREQ = NBUS * NCH;
  localparam int CIW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BIW  = (NBUS > 1) ? $clog2(NBUS) : 1;

  logic [NREQ-1:0] pend_r;
  logic [NREQ-1:0] en_rep_s;
  logic [NREQ-1:0] en_pend_s;
  logic [NREQ-1:0] clr_s;
  logic [NREQ-1:0] pend_nxt_s;
  logic [KEYW-1:0] keyreg_r;

  intc_state_e     state_r;
  intc_state_e     state_nxt_s;

  logic [NBUS-1:0] bus_found_s;
  logic [CIW-1:0]  bus_idx_s [NBUS];
  logic            win_found_s;
  logic [BIW-1:0]  win_bus_s;
  logic [CIW-1:0]  win_chan_s;

  logic            valid_nxt_s;
  logic [BUSW-1:0] bus_nxt_s;
  logic [CHW-1:0]  chan_nxt_s;
  logic            ack_clr_s;

  // Replicate the per-channel enable across every bus.
  always_comb begin
    en_rep_s = {NREQ{1'b0}};
    for (int b = 0; b < NBUS; b++) begin
      for (int c = 0; c < NCH; c++) begin
        en_rep_s[flat_idx(b, c, NCH)] = chan_en[c];
      end
    end
  end

  assign en_pend_s = pend_r & en_rep_s;

  // One finder per bus picks the lowest enabled channel; a final finder picks the lowest bus.
  for (genvar b = 0; b < NBUS; b++) begin : g_bus
    prio_find_first #(.W(NCH)) u_chan_find (
      .vec   (en_pend_s[b*NCH +: NCH]),
      .found (bus_found_s[b]),
      .idx   (bus_idx_s[b])
    );
  end

  prio_find_first #(.W(NBUS)) u_bus_find (
    .vec   (bus_found_s),
    .found (win_found_s),
    .idx   (win_bus_s)
  );

  assign win_chan_s = bus_idx_s[win_bus_s];

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = irq_valid;
    bus_nxt_s   = irq_bus;
    chan_nxt_s  = irq_chan;
    ack_clr_s   = 1'b0;
    case (state_r)
      LOCKED: begin
        valid_nxt_s = 1'b0;
        if (key_ok) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      IDLE: begin
        if (!key_ok) begin
          state_nxt_s = LOCKED;
          valid_nxt_s = 1'b0;
        end else if (win_found_s) begin
          state_nxt_s = GRANT;
          valid_nxt_s = 1'b1;
          bus_nxt_s   = BUSW'(win_bus_s);
          chan_nxt_s  = CHW'(win_chan_s);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        // A lost key aborts the grant; the pending bit is left for later.
        if (!key_ok) begin
          state_nxt_s = LOCKED;
          valid_nxt_s = 1'b0;
        end else if (irq_ack) begin
          state_nxt_s = IDLE;
          valid_nxt_s = 1'b0;
          ack_clr_s   = 1'b1;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = LOCKED;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Clear mask for the acknowledged pending bit.
  always_comb begin
    clr_s = {NREQ{1'b0}};
    if (ack_clr_s) begin
      clr_s[flat_idx(int'(irq_bus), int'(irq_chan), NCH)] = 1'b1;
    end else begin
      clr_s = {NREQ{1'b0}};
    end
  end

  // Set after clear so a request arriving with the ack of the same bit is kept.
  assign pend_nxt_s = (pend_r & ~clr_s) | (req & en_rep_s);

  // Pending array and its summary flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r   <= {NREQ{1'b0}};
      pend_any <= 1'b0;
    end else begin
      pend_r   <= pend_nxt_s;
      pend_any <= |(pend_nxt_s & en_rep_s);
    end
  end

  // Serial key register and its registered compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      keyreg_r <= {KEYW{1'b0}};
      key_ok   <= (KEY == {KEYW{1'b0}});
    end else begin
      if (key_shift) begin
        keyreg_r <= {keyreg_r[KEYW-2:0], key_in};
      end
      key_ok <= (keyreg_r == KEY);
    end
  end

  // FSM state and presented winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= LOCKED;
      irq_valid <= 1'b0;
      irq_bus   <= {BUSW{1'b0}};
      irq_chan  <= {CHW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      irq_valid <= valid_nxt_s;
      irq_bus   <= bus_nxt_s;
      irq_chan  <= chan_nxt_s;
    end
  end

endmodule

// File: tb/tb_keyed_prio_intc.sv
// Self-checking bench for keyed_prio_intc.
// A behavioural model advances once per clock with the stimulus and pushes
// the expected outputs into a queue; a monitor on the falling edge pops one
// expectation per cycle and compares it with the DUT outputs.
module tb_keyed_prio_intc;

  localparam int              NCH  = 9;
  localparam int              NBUS = 3;
  localparam int              NR   = NBUS * NCH;
  localparam int              KEYW = 12;
  localparam logic [KEYW-1:0] KEY  = 12'hA5C;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NCH-1:0]  chan_en;
  logic            key_in;
  logic            key_shift;
  logic            irq_valid;
  logic [1:0]      irq_bus;
  logic [4:0]      irq_chan;
  logic            irq_ack;
  logic            pend_any;
  logic            key_ok;

  keyed_prio_intc #(.NCH(NCH), .NBUS(NBUS), .KEYW(KEYW), .KEY(KEY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .chan_en   (chan_en),
    .key_in    (key_in),
    .key_shift (key_shift),
    .irq_valid (irq_valid),
    .irq_bus   (irq_bus),
    .irq_chan  (irq_chan),
    .irq_ack   (irq_ack),
    .pend_any  (pend_any),
    .key_ok    (key_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: pending matrix, key shifter, and whether the
  // controller is unlocked (open) and currently presenting (valid).
  bit             m_pend [NBUS][NCH];
  logic           m_open, m_valid, m_pa, m_ko;
  int             m_bus, m_chan;
  logic [KEYW-1:0] m_keyreg;

  logic [9:0]     exp_q [$];
  logic [9:0]     mon_e, mon_a;
  int             checks = 0;
  int             passes = 0;
  int             cyc_n  = 0;
  logic [NCH-1:0] cur_en;
  logic [KEYW-1:0] key_v;

  task automatic model_edge(input logic r, input logic [NR-1:0] rq, input logic [NCH-1:0] en,
                            input logic kb, input logic ks, input logic ak);
    logic old_ko;
    logic hit;
    int   cb, cc;
    old_ko = m_ko;
    cb = -1;
    cc = -1;
    if (r) begin
      foreach (m_pend[b, c]) m_pend[b][c] = 1'b0;
      m_open = 1'b0; m_valid = 1'b0; m_bus = 0; m_chan = 0;
      m_pa = 1'b0; m_keyreg = '0; m_ko = (KEY == 12'h000);
      return;
    end
    if (!m_open) begin
      m_open = old_ko;
    end else if (!m_valid) begin
      if (!old_ko) begin
        m_open = 1'b0;
      end else begin
        hit = 1'b0;
        for (int b = 0; b < NBUS; b++)
          for (int c = 0; c < NCH; c++)
            if (!hit && m_pend[b][c] && en[c]) begin
              hit = 1'b1; m_bus = b; m_chan = c;
            end
        if (hit) m_valid = 1'b1;
      end
    end else begin
      if (!old_ko) begin
        m_open = 1'b0; m_valid = 1'b0;
      end else if (ak) begin
        cb = m_bus; cc = m_chan; m_valid = 1'b0;
      end
    end
    m_pa = 1'b0;
    for (int b = 0; b < NBUS; b++)
      for (int c = 0; c < NCH; c++) begin
        if (b == cb && c == cc) m_pend[b][c] = 1'b0;
        if (rq[b*NCH+c] && en[c]) m_pend[b][c] = 1'b1;
        if (m_pend[b][c] && en[c]) m_pa = 1'b1;
      end
    m_ko = (m_keyreg == KEY);
    if (ks) m_keyreg = {m_keyreg[KEYW-2:0], kb};
  endtask

  // One clock of stimulus: drive inputs after the falling edge, advance the model, queue the expectation.
  task automatic cyc(input logic r, input logic [NR-1:0] rq, input logic kb, input logic ks, input logic ak);
    logic [1:0] eb;
    logic [4:0] ec;
    @(negedge clk);
    #1;
    rst = r; req = rq; chan_en = cur_en; key_in = kb; key_shift = ks; irq_ack = ak;
    model_edge(r, rq, cur_en, kb, ks, ak);
    eb = m_bus[1:0];
    ec = m_chan[4:0];
    exp_q.push_back({m_valid, eb, ec, m_pa, m_ko});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_key(input logic [KEYW-1:0] k);
    for (int i = KEYW - 1; i >= 0; i--) cyc(1'b0, '0, k[i], 1'b1, 1'b0);
  endtask

  // Acknowledge the next grant the model expects (bounded wait), optionally with a request in the same cycle.
  task automatic ack_grant(input logic [NR-1:0] rq);
    for (int i = 0; i < 20; i++) begin
      if (m_valid) begin
        cyc(1'b0, rq, 1'b0, 1'b0, 1'b1);
        return;
      end
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [NR-1:0] bit_at(input int b, input int c);
    logic [NR-1:0] v;
    v = '0;
    v[b*NCH+c] = 1'b1;
    return v;
  endfunction

  // Monitor: one expectation per clock, compared away from the rising edge.
  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {irq_valid, irq_bus, irq_chan, pend_any, key_ok};
      checks = checks + 1;
      if (mon_a === mon_e) begin
        passes = passes + 1;
      end else begin
        $display("FAIL outputs cycle %0d: got valid=%b bus=%0d chan=%0d pend_any=%b key_ok=%b, want valid=%b bus=%0d chan=%0d pend_any=%b key_ok=%b",
                 cyc_n, mon_a[9], mon_a[8:7], mon_a[6:2], mon_a[1], mon_a[0],
                 mon_e[9], mon_e[8:7], mon_e[6:2], mon_e[1], mon_e[0]);
      end
    end
  end

  initial begin
    logic [NR-1:0] rq;
    logic          kb, ks, ak, r;
    int            ph;
    rst = 1'b1; req = '0; chan_en = '1; key_in = 1'b0; key_shift = 1'b0; irq_ack = 1'b0;
    cur_en = '1;
    key_v  = KEY;
    m_open = 1'b0; m_valid = 1'b0; m_pa = 1'b0; m_ko = 1'b0; m_bus = 0; m_chan = 0; m_keyreg = '0;

    // Reset, then a request while locked: nothing may be presented.
    repeat (3) cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, bit_at(0, 3), 1'b0, 1'b0, 1'b0);
    idle(50);

    // Unlock, then the pending bus0 ch3 is granted and acknowledged.
    shift_key(KEY);
    idle(1);
    ack_grant('0);
    idle(2);

    // Bus priority: bus1 ch8 beats bus2 ch0.
    cyc(1'b0, bit_at(2, 0) | bit_at(1, 8), 1'b0, 1'b0, 1'b0);
    ack_grant('0);
    ack_grant('0);
    idle(2);

    // Grant stability against a later higher-priority request.
    cyc(1'b0, bit_at(1, 5), 1'b0, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, bit_at(0, 0), 1'b0, 1'b0, 1'b0);
    idle(2);
    ack_grant('0);
    ack_grant('0);
    idle(2);

    // Channel enable: disabled channel does not latch; a pending masked bit waits for re-enable.
    cur_en[4] = 1'b0;
    cyc(1'b0, bit_at(0, 4), 1'b0, 1'b0, 1'b0);
    idle(3);
    cur_en = '1;
    cyc(1'b0, bit_at(1, 1), 1'b0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, bit_at(0, 4), 1'b0, 1'b0, 1'b0);
    cur_en[4] = 1'b0;
    ack_grant('0);
    idle(4);
    cur_en[4] = 1'b1;
    ack_grant('0);
    idle(2);

    // Ack and a new request on the same bit in one cycle: the request survives.
    cyc(1'b0, bit_at(0, 2), 1'b0, 1'b0, 1'b0);
    idle(2);
    ack_grant(bit_at(0, 2));
    ack_grant('0);
    idle(2);

    // Key lost during GRANT aborts; re-key regrants; reset mid-GRANT.
    cyc(1'b0, bit_at(0, 2), 1'b0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(3);
    shift_key(KEY);
    idle(4);
    cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Randomised traffic with periodic key loss / reload and one reset.
    for (int i = 0; i < 400; i++) begin
      rq = NR'($urandom & $urandom & $urandom);
      cur_en = ($urandom_range(0, 3) == 0) ? ~NCH'($urandom & $urandom) : {NCH{1'b1}};
      ak = ($urandom_range(0, 2) == 0);
      r  = (i == 250);
      ph = i % 80;
      ks = 1'b0;
      kb = 1'b0;
      if (ph == 40) begin
        ks = 1'b1; kb = 1'b1;
      end else if (ph >= 50 && ph < 62) begin
        ks = 1'b1; kb = key_v[61 - ph];
      end
      cyc(r, rq, kb, ks, ak);
    end

    @(negedge clk);
    #2;
    checks = checks + 1;
    if (exp_q.size() == 0) passes = passes + 1;
    else $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
